vector_sum_sequencer: RTL and testbench

- Serial, resource-shared counterpart to the combinational adder tree: one DATA_WIDTH adder is time-multiplexed over the N elements of a packed vector, one element per clock.
- Vectors arrive on a valid/ready input handshake; the sum leaves on a valid/ready output handshake.
- Used where the area of N-1 parallel adders is not affordable and N+2 cycles per vector is acceptable.

---
 rtl/vector_sum_sequencer_if.sv | 32 +++
 rtl/vector_sum_sequencer.sv | 123 ++++++++++++
 tb/tb_vector_sum_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_sum_sequencer_if.sv
// vector_sum_sequencer_if
// Bundles the input vector handshake, the result handshake and the busy
// flag of vector_sum_sequencer into one interface.
//   in_valid / in_ready / in_vec   : vector handshake (producer -> block)
//   out_valid / out_ready          : result handshake (block -> consumer)
//   out_sum / out_ovf              : result payload, valid with out_valid
//   busy                           : block is accumulating or holding a result
// modport slave is the block's view; modport master is the environment's view.
// N and DATA_WIDTH must match the parameters of the attached block.
interface vector_sum_sequencer_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N*DATA_WIDTH-1:0]   in_vec;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_sum;
  logic                      out_ovf;
  logic                      busy;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/vector_sum_sequencer.sv
// vector_sum_sequencer
// Sums the N DATA_WIDTH-bit elements of a packed vector with a single shared
// adder, one element per clock. A vector is taken on the input handshake,
// accumulated over N cycles, and the sum is offered on the output handshake
// until the consumer takes it.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : vector_sum_sequencer_if.slave (in_valid/in_ready/in_vec,
//          out_valid/out_ready/out_sum/out_ovf, busy)
// Element 0 is the MSB slice of in_vec; element N-1 is the LSB slice.
// out_sum wraps modulo 2^DATA_WIDTH; out_ovf is set if any carry-out
// occurred while accumulating the current vector.
module vector_sum_sequencer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_sum_sequencer_if.slave   bus
);

  localparam int VEC_WIDTH = N * DATA_WIDTH;
  localparam int CNT_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [VEC_WIDTH-1:0]   vec_q, vec_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [DATA_WIDTH-1:0]  elem;
  logic [DATA_WIDTH:0]    sum_w;

  // The vector register is shifted left one element per ACCUM cycle, so the
  // element to add is always its MSB slice; element 0 is added first.
  assign elem  = vec_q[VEC_WIDTH-1 -: DATA_WIDTH];
  assign sum_w = {1'b0, acc_q} + {1'b0, elem};

  // Next-state logic. The handshake flags are registered from the next state,
  // so they always equal a pure decode of state_q and never depend
  // combinationally on in_valid or out_ready.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d   = bus.in_vec;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = sum_w[DATA_WIDTH-1:0];
        ovf_d = ovf_q | sum_w[DATA_WIDTH];
        cnt_d = cnt_q + CNT_WIDTH'(1);
        vec_d = vec_q << DATA_WIDTH;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any vector in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      vec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_vector_sum_sequencer.sv
// tb_vector_sum_sequencer
// Directed self-checking bench for vector_sum_sequencer: an N=4 instance for
// the main sequence and an N=1 instance for the single-element case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vector_sum_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vector_sum_sequencer_if #(.N(4), .DATA_WIDTH(16)) bus  ();
  vector_sum_sequencer_if #(.N(1), .DATA_WIDTH(16)) bus1 ();

  vector_sum_sequencer #(.N(4), .DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vector_sum_sequencer #(.N(1), .DATA_WIDTH(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle: the rising edge happens, then we are at the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] vec, input logic ready);
    bus.in_valid  = valid;
    bus.in_vec    = vec;
    bus.out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a vector for exactly one accepting edge, then scramble in_vec
  task automatic sendVector(input logic [63:0] vec, input logic ready);
    applyStimulus(1'b1, vec, ready);
    tick();
    applyStimulus(1'b0, {$urandom, $urandom}, ready);
  endtask

  // Called at the falling edge right after the accept edge. Counts cycles
  // until out_valid and how many sampled cycles had in_ready low.
  task automatic waitDone(output int latency, output int low_count);
    latency   = 0;
    low_count = bus.in_ready ? 0 : 1;
    while (!bus.out_valid && latency < 30) begin
      tick();
      latency++;
      if (!bus.in_ready) low_count++;
    end
  endtask

  initial begin
    int latency;
    int low_count;
    int first_acc;
    int second_acc;
    int t;
    int saw_valid;

    checks = 0;
    errors = 0;
    bus1.in_valid  = 1'b0;
    bus1.in_vec    = 16'h0;
    bus1.out_ready = 1'b1;

    // Reset held two cycles with a vector offered: nothing must be captured
    rst = 1'b1;
    applyStimulus(1'b1, {16'd1, 16'd2, 16'd3, 16'd4}, 1'b1);
    tick();
    tick();
    checkOutput("rst_in_ready",  bus.in_ready,  1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy",      bus.busy,      0);
    checkOutput("rst_out_sum",   bus.out_sum,   0);
    checkOutput("rst_out_ovf",   bus.out_ovf,   0);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("post_rst_idle", bus.busy, 0);

    // Basic sum 1+2+3+4
    sendVector({16'd1, 16'd2, 16'd3, 16'd4}, 1'b1);
    checkOutput("basic_busy", bus.busy, 1);
    waitDone(latency, low_count);
    checkOutput("basic_latency", latency, 4);
    checkOutput("basic_sum", bus.out_sum, 10);
    checkOutput("basic_ovf", bus.out_ovf, 0);
    tick();
    checkOutput("basic_valid_drop", bus.out_valid, 0);
    checkOutput("basic_back_idle", bus.in_ready, 1);
    // N ACCUM cycles plus one DONE cycle
    checkOutput("basic_ready_low", low_count, 5);

    // Wrap with carry-out
    sendVector({16'hFFFF, 16'h0002, 16'h0000, 16'h0000}, 1'b1);
    waitDone(latency, low_count);
    checkOutput("wrap_sum", bus.out_sum, 16'h0001);
    checkOutput("wrap_ovf", bus.out_ovf, 1);
    tick();

    // Largest sum without carry: flag must be cleared for the new vector
    sendVector({16'h8000, 16'h7FFF, 16'h0000, 16'h0000}, 1'b1);
    waitDone(latency, low_count);
    checkOutput("nowrap_sum", bus.out_sum, 16'hFFFF);
    checkOutput("nowrap_ovf", bus.out_ovf, 0);
    tick();

    // Back-pressure: result held for 10 cycles while inputs churn
    sendVector({16'd10, 16'd20, 16'd30, 16'd40}, 1'b0);
    waitDone(latency, low_count);
    checkOutput("bp_latency", latency, 4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom), {$urandom, $urandom}, 1'b0);
      tick();
      checkOutput("bp_valid", bus.out_valid, 1);
      checkOutput("bp_sum",   bus.out_sum,   100);
      checkOutput("bp_ready", bus.in_ready,  0);
    end
    applyStimulus(1'b0, 64'h0, 1'b1);
    tick();
    checkOutput("bp_release_valid", bus.out_valid, 0);
    checkOutput("bp_release_idle",  bus.in_ready,  1);
    tick();
    checkOutput("bp_single_xfer", bus.out_valid, 0);

    // Element order: element 0 (MSB slice) is added on the first ACCUM edge
    sendVector({16'd100, 16'd0, 16'd0, 16'd0}, 1'b1);
    tick();
    checkOutput("order_first_add", bus.out_sum, 100);
    waitDone(latency, low_count);
    checkOutput("order_sum", bus.out_sum, 100);
    tick();

    // Back-to-back: in_valid held high, accepts must be N+2 cycles apart
    applyStimulus(1'b1, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1);
    t          = 0;
    first_acc  = -1;
    second_acc = -1;
    while (second_acc < 0 && t < 40) begin
      if (bus.in_ready) begin
        if (first_acc < 0) first_acc = t;
        else second_acc = t;
      end
      tick();
      t++;
    end
    checkOutput("b2b_spacing", second_acc - first_acc, 6);
    applyStimulus(1'b0, 64'h0, 1'b1);
    t = 0;
    while (!bus.in_ready && t < 20) begin
      tick();
      t++;
    end
    checkOutput("b2b_drain", bus.in_ready, 1);

    // Mid-operation reset on the second ACCUM cycle
    sendVector({16'd7, 16'd7, 16'd7, 16'd7}, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_ready", bus.in_ready,  1);
    checkOutput("midrst_busy",  bus.busy,      0);
    checkOutput("midrst_sum",   bus.out_sum,   0);
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) saw_valid = 1;
    end
    checkOutput("midrst_no_valid", saw_valid, 0);
    sendVector({16'd5, 16'd5, 16'd5, 16'd5}, 1'b1);
    waitDone(latency, low_count);
    checkOutput("after_rst_sum", bus.out_sum, 20);
    tick();

    // N=1 instance: one ACCUM cycle, result is element 0
    bus1.in_valid = 1'b1;
    bus1.in_vec   = 16'h1234;
    tick();
    bus1.in_valid = 1'b0;
    bus1.in_vec   = 16'hDEAD;
    checkOutput("n1_accum", bus1.out_valid, 0);
    tick();
    checkOutput("n1_valid", bus1.out_valid, 1);
    checkOutput("n1_sum",   bus1.out_sum,   16'h1234);
    checkOutput("n1_ovf",   bus1.out_ovf,   0);
    tick();
    bus1.in_valid = 1'b1;
    bus1.in_vec   = 16'hFFFF;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    checkOutput("n1_max_sum", bus1.out_sum, 16'hFFFF);
    checkOutput("n1_max_ovf", bus1.out_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
